// File: rtl/comparator_pkg.sv
// Shared constants for the registered magnitude comparator.
// The one-hot result is ordered {gt, eq, lt}; NONE is only seen during and right after reset.
package comparator_pkg;

    localparam int unsigned DEFAULT_WIDTH = 2;
    localparam int unsigned RES_W         = 3;

    localparam logic [RES_W-1:0] RES_GT   = 3'b100;
    localparam logic [RES_W-1:0] RES_EQ   = 3'b010;
    localparam logic [RES_W-1:0] RES_LT   = 3'b001;
    localparam logic [RES_W-1:0] RES_NONE = 3'b000;

    // Bit positions inside the result vector.
    localparam int unsigned RES_GT_BIT = 2;
    localparam int unsigned RES_EQ_BIT = 1;
    localparam int unsigned RES_LT_BIT = 0;

endpackage

// File: rtl/comparator_core.sv
// Combinational compare of A against B, producing the {gt, eq, lt} one-hot result.
// Configuration macro: COMPARATOR_SIGNED_EN selects two's-complement ordering for gt/lt.
module comparator_core
    import comparator_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [RES_W-1:0] res_c
);

    logic a_eq_b;
    logic a_gt_b;

    assign a_eq_b = (A == B);

`ifdef COMPARATOR_SIGNED_EN
    // Signed ordering: the MSB carries negative weight.
    assign a_gt_b = ($signed(A) > $signed(B));
`else
    // Unsigned ordering: width-exact, so no overflow case exists.
    assign a_gt_b = (A > B);
`endif

    // Encode the decision; equality wins first so exactly one bit is ever set.
    always_comb begin
        res_c = RES_NONE;
        if (a_eq_b) begin
            res_c = RES_EQ;
        end else if (a_gt_b) begin
            res_c = RES_GT;
        end else begin
            res_c = RES_LT;
        end
    end

endmodule

// File: rtl/comparator.sv
// Registered magnitude comparator: one-cycle latency from A/B to the three flags.
// Configuration macro: COMPARATOR_SIGNED_EN (see comparator_core).
module comparator
    import comparator_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             A_gt_B_reg,
    output logic             A_eq_B_reg,
    output logic             A_lt_B_reg
);

    logic [RES_W-1:0] res_c;
    logic [RES_W-1:0] res_q;

    comparator_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .A     (A),
        .B     (B),
        .res_c (res_c)
    );

    // Flag register: cleared immediately by reset, loads all three flags together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= RES_NONE;
        end else begin
            res_q <= res_c;
        end
    end

    assign A_gt_B_reg = res_q[RES_GT_BIT];
    assign A_eq_B_reg = res_q[RES_EQ_BIT];
    assign A_lt_B_reg = res_q[RES_LT_BIT];

endmodule

// File: tb/tb_comparator.sv
// Scoreboard bench for comparator: a WIDTH=2 and a WIDTH=8 instance driven in lockstep.
// Honours COMPARATOR_SIGNED_EN when computing expected flags.
module tb_comparator;

    typedef struct {
        logic [2:0] e2;
        logic [2:0] e8;
        int         id;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [1:0] a2, b2;
    logic [7:0] a8, b8;
    logic       gt2, eq2, lt2;
    logic       gt8, eq8, lt8;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   vec_id   = 0;

`ifdef COMPARATOR_SIGNED_EN
    localparam bit SIGNED_MODE = 1'b1;
`else
    localparam bit SIGNED_MODE = 1'b0;
`endif

    comparator #(.WIDTH(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .A          (a2),
        .B          (b2),
        .A_gt_B_reg (gt2),
        .A_eq_B_reg (eq2),
        .A_lt_B_reg (lt2)
    );

    comparator #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .A          (a8),
        .B          (b8),
        .A_gt_B_reg (gt8),
        .A_eq_B_reg (eq8),
        .A_lt_B_reg (lt8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ordering using integer arithmetic; sign handled by subtracting 2^w.
    function automatic logic [2:0] model(input int a, input int b, input int w);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (SIGNED_MODE) begin
            if (a >= (1 << (w - 1))) sa = a - (1 << w);
            if (b >= (1 << (w - 1))) sb = b - (1 << w);
        end
        if (sa == sb)     return 3'b010;
        else if (sa > sb) return 3'b100;
        else              return 3'b001;
    endfunction

    task automatic check(input string name, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got gt/eq/lt=%b expected %b", name, got, exp);
        end
    endtask

    // Drive one operand set on the falling edge and record what the next rising edge must yield.
    task automatic apply(input logic [1:0] va2, input logic [1:0] vb2,
                         input logic [7:0] va8, input logic [7:0] vb8,
                         input logic [2:0] e2, input logic [2:0] e8);
        exp_t e;
        @(negedge clk);
        a2 = va2;
        b2 = vb2;
        a8 = va8;
        b8 = vb8;
        e.e2 = e2;
        e.e8 = e8;
        e.id = vec_id;
        vec_id++;
        q.push_back(e);
    endtask

    task automatic apply_model(input logic [1:0] va2, input logic [1:0] vb2,
                               input logic [7:0] va8, input logic [7:0] vb8);
        apply(va2, vb2, va8, vb8,
              model(int'(va2), int'(vb2), 2), model(int'(va8), int'(vb8), 8));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 10) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected results never consumed, expected 0", q.size());
        end
    endtask

    // Monitor: every rising edge with rst low presents a new result one step later.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            check($sformatf("w2_vec%0d", e.id), {gt2, eq2, lt2}, e.e2);
            check($sformatf("w8_vec%0d", e.id), {gt8, eq8, lt8}, e.e8);
            checks++;
            if (!$onehot({gt2, eq2, lt2}) || !$onehot({gt8, eq8, lt8})) begin
                failures++;
                $display("FAIL onehot_vec%0d: got w2=%b w8=%b expected one-hot",
                         e.id, {gt2, eq2, lt2}, {gt8, eq8, lt8});
            end
        end
    end

    // Directed boundary table: {a2, b2, a8, b8, unsigned w2, unsigned w8, signed w2, signed w8}.
    logic [1:0] da2 [4] = '{2'd3, 2'd1, 2'd2, 2'd3};
    logic [1:0] db2 [4] = '{2'd0, 2'd2, 2'd2, 2'd1};
    logic [7:0] da8 [4] = '{8'd255, 8'd0,   8'd255, 8'd0};
    logic [7:0] db8 [4] = '{8'd0,   8'd255, 8'd255, 8'd0};
    logic [2:0] eu2 [4] = '{3'b100, 3'b001, 3'b010, 3'b100};
    logic [2:0] eu8 [4] = '{3'b100, 3'b001, 3'b010, 3'b010};
    logic [2:0] es2 [4] = '{3'b001, 3'b100, 3'b010, 3'b001};
    logic [2:0] es8 [4] = '{3'b001, 3'b100, 3'b010, 3'b010};

    initial begin
        logic [2:0] held;
        rst = 1'b1;
        a2 = '0; b2 = '0; a8 = '0; b8 = '0;

        // Reset holds flags low across clock edges, and release alone changes nothing.
        repeat (2) @(negedge clk);
        check("reset_w2", {gt2, eq2, lt2}, 3'b000);
        check("reset_w8", {gt8, eq8, lt8}, 3'b000);
        rst = 1'b0;
        #1;
        check("release_w2", {gt2, eq2, lt2}, 3'b000);

        // Exhaustive 2-bit sweep, each pair held for two cycles.
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                repeat (2) apply_model(2'(i), 2'(j), 8'(i * 60), 8'(j * 60));
            end
        end
        drain();

        // Second reset after last pair (3,3), then first capture (1,0) gives gt.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset2_w2", {gt2, eq2, lt2}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        apply(2'd1, 2'd0, 8'd1, 8'd0, 3'b100, 3'b100);

        // Latency: A changes 1->3 with B=2; old result holds until the next edge.
        apply_model(2'd1, 2'd2, 8'd1, 8'd2);
        drain();
        held = model(1, 2, 2);
        @(negedge clk);
        a2 = 2'd3;
        a8 = 8'd3;
        #1;
        check("latency_hold_w2", {gt2, eq2, lt2}, held);
        check("latency_hold_w8", {gt8, eq8, lt8}, 3'b001);
        apply_model(2'd3, 2'd2, 8'd3, 8'd2);

        // Boundary and sign-sensitive vectors with hand-computed results.
        for (int k = 0; k < 4; k++) begin
            if (SIGNED_MODE) apply(da2[k], db2[k], da8[k], db8[k], es2[k], es8[k]);
            else             apply(da2[k], db2[k], da8[k], db8[k], eu2[k], eu8[k]);
        end
        apply(2'b10, 2'b10, 8'd0, 8'd0, 3'b010, 3'b010);
        drain();

        // Asynchronous mid-cycle reset clears flags without an edge.
        apply(2'd0, 2'd3, 8'd0, 8'd255, SIGNED_MODE ? 3'b100 : 3'b001,
              SIGNED_MODE ? 3'b100 : 3'b001);
        drain();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset_w2", {gt2, eq2, lt2}, 3'b000);
        check("async_reset_w8", {gt8, eq8, lt8}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        apply(2'd2, 2'd2, 8'd7, 8'd7, 3'b010, 3'b010);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
